exc_ctl: RTL and testbench
==========================

Name: exc_ctl

Overview:
- Exception/interrupt sequencer for the single-cycle MIPS core.
- Latches external interrupt requests and illegal-op events, and captures EPC and cause.
- Sequences the trap: it drives the decoder's irq input for the link-register write, redirects the PC to the handler vector, and holds supervisorBit until the handler returns via eret.
- Sits between the fetch/PC logic and the main decoder.

Parameters:
- IRQ_LINES, 4, number of external interrupt lines (legal range 1..8).
- VECTOR_ADDR, 32'h0000_0080, handler entry address.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- irq_req  in  IRQ_LINES  external interrupt lines, level; only rising edges are events
- irq_en  in  1  global interrupt enable
- retire  in  1  current instruction commits this cycle
- illOp  in  1  decoder flag: current instruction is illegal
- eret  in  1  current instruction is exception-return
- pc_cur  in  32  PC of the current instruction
- irq  out  1  trap request to the decoder (link write)
- supervisorBit  out  1  core is in handler mode
- pc_redirect  out  1  fetch takes redirect_pc next cycle
- redirect_pc  out  32  redirect target
- epc  out  32  saved exception PC
- cause  out  4  trap cause: 0 none, 1 illegal op, 8+i IRQ line i
- irq_ack  out  IRQ_LINES  one-cycle acknowledge, one-hot
- double_fault  out  1  sticky: illegal op retired inside handler

Behaviour:
- Reset values: state RUN, pending=0, irq/pc_redirect/irq_ack=0, supervisorBit=0, redirect_pc=0, epc=0, cause=0, double_fault=0.
- Reset overrides everything, including mid-trap or mid-handler.
- Pending latch:
  - pending[i] sets on a rising edge of irq_req[i] (registered previous value) in any state.
  - pending[i] clears when irq_ack[i] pulses.
  - Edge and ack on the same line in the same cycle: pending stays 1.
- State RUN (supervisorBit=0):
  - retire && illOp → TRAP; epc<=pc_cur, cause<=1.
  - Otherwise retire && irq_en && |pending → TRAP; epc<=pc_cur, cause<=8+lowest set index, line recorded for ack.
  - Illegal op has priority over interrupts. Lower IRQ index has higher priority.
  - No retire → no trap; events stay pending.
- State TRAP (1 cycle): irq=1 and supervisorBit=0, so the decoder performs the link write. Next state VECTOR.
- State VECTOR (1 cycle):
  - pc_redirect=1, redirect_pc=VECTOR_ADDR, supervisorBit=1.
  - irq_ack pulses for the recorded line (none if cause=1).
  - Next state HANDLER.
- State HANDLER (supervisorBit=1):
  - New edges are latched into pending but not taken.
  - retire && illOp sets double_fault; state is unchanged and epc/cause are not overwritten.
  - retire && eret → RETURN.
- State RETURN (1 cycle):
  - pc_redirect=1, redirect_pc=epc, supervisorBit=1.
  - Next state RUN with supervisorBit=0.
  - A pending IRQ may trap on the first retire in RUN (earliest: the cycle after entering RUN).
- eret outside HANDLER is ignored.
- epc and cause hold their values until the next trap entry.
- Trap latency: retire at cycle N → irq=1 at N+1 → redirect at N+2.

Decomposition:
- Package exc_pkg:
  - state enum {RUN, TRAP, VECTOR, HANDLER, RETURN};
  - cause constants CAUSE_NONE=0, CAUSE_ILLOP=1, CAUSE_IRQ_BASE=8;
  - cause width constant.
- Sub-module irq_pending: edge detect, pending register, ack clear, lowest-index priority encoder.
  - Outputs: any_pending, sel_index.

Test Plan:
- Illegal op: pc_cur=0x40, retire=1, illOp=1 in RUN → next cycle irq=1, epc=0x40, cause=1; then pc_redirect=1 with redirect_pc=0x80 and supervisorBit=1; irq_ack stays 0.
- IRQ priority: rising edges on lines 2 and 1 in the same cycle, irq_en=1, retire at pc_cur=0x100 → cause=9, irq_ack=4'b0010 in VECTOR, pending[2] remains set; after eret the next retire traps with cause=10.
- Masking: irq_req[0] edge with irq_en=0 and 20 retires → no trap; set irq_en=1 → trap on the next retire, cause=8.
- Handler nesting/return: IRQ edge during HANDLER is not taken; eret+retire → RETURN with redirect_pc=epc; supervisorBit=0 in the following cycle; the pending IRQ traps on the next retire.
- Double fault: illOp+retire in HANDLER → double_fault=1, epc/cause unchanged, state stays HANDLER; double_fault is held until reset.
- Reset mid-trap: assert reset during VECTOR → next cycle all outputs at reset values, pending=0, state RUN.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt sequencer.
package exc_pkg;

    typedef enum logic [2:0] {
        RUN,
        TRAP,
        VECTOR,
        HANDLER,
        RETURN
    } exc_state_t;

    localparam int CAUSE_W = 4;
    localparam int IDX_W   = 3;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE     = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLOP    = 4'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_IRQ_BASE = 4'd8;

endpackage

// File: rtl/exc_ctl_irq_pending.sv
// Rising-edge interrupt latch with acknowledge clear and lowest-index priority select.
module irq_pending
    import exc_pkg::*;
#(
    parameter int IRQ_LINES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IRQ_LINES-1:0] irq_req,
    input  logic [IRQ_LINES-1:0] irq_ack,
    output logic [IRQ_LINES-1:0] pending,
    output logic                 any_pending,
    output logic [IDX_W-1:0]     sel_index
);

    logic [IRQ_LINES-1:0] req_prev;
    logic [IRQ_LINES-1:0] req_rise;

    assign req_rise = irq_req & ~req_prev;

    // During reset the previous value tracks the lines so a held line is not
    // mistaken for a fresh edge once reset is released.
    always_ff @(posedge clk) begin
        req_prev <= irq_req;
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~irq_ack) | req_rise;
        end
    end

    assign any_pending = |pending;

    always_comb begin
        sel_index = '0;
        for (int i = IRQ_LINES - 1; i >= 0; i--) begin
            if (pending[i]) sel_index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/exc_ctl.sv
// Trap sequencer: RUN -> TRAP (link write) -> VECTOR (redirect) -> HANDLER -> RETURN.
module exc_ctl
    import exc_pkg::*;
#(
    parameter int          IRQ_LINES   = 4,
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0080
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IRQ_LINES-1:0] irq_req,
    input  logic                 irq_en,
    input  logic                 retire,
    input  logic                 illOp,
    input  logic                 eret,
    input  logic [31:0]          pc_cur,
    output logic                 irq,
    output logic                 supervisorBit,
    output logic                 pc_redirect,
    output logic [31:0]          redirect_pc,
    output logic [31:0]          epc,
    output logic [CAUSE_W-1:0]   cause,
    output logic [IRQ_LINES-1:0] irq_ack,
    output logic                 double_fault
);

    exc_state_t           state;
    logic [IRQ_LINES-1:0] pending;
    logic                 any_pending;
    logic [IDX_W-1:0]     sel_index;
    logic [IRQ_LINES-1:0] sel_onehot;
    logic [IRQ_LINES-1:0] ack_mask;

    irq_pending #(.IRQ_LINES(IRQ_LINES)) u_pend (
        .clk         (clk),
        .reset       (reset),
        .irq_req     (irq_req),
        .irq_ack     (irq_ack),
        .pending     (pending),
        .any_pending (any_pending),
        .sel_index   (sel_index)
    );

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < IRQ_LINES; i++) begin
            sel_onehot[i] = (sel_index == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            irq           <= 1'b0;
            supervisorBit <= 1'b0;
            pc_redirect   <= 1'b0;
            redirect_pc   <= '0;
            epc           <= '0;
            cause         <= CAUSE_NONE;
            irq_ack       <= '0;
            ack_mask      <= '0;
            double_fault  <= 1'b0;
        end else begin
            irq         <= 1'b0;
            pc_redirect <= 1'b0;
            irq_ack     <= '0;
            case (state)
                RUN: begin
                    supervisorBit <= 1'b0;
                    if (retire && illOp) begin
                        state    <= TRAP;
                        irq      <= 1'b1;
                        epc      <= pc_cur;
                        cause    <= CAUSE_ILLOP;
                        ack_mask <= '0;
                    end else if (retire && irq_en && any_pending) begin
                        state    <= TRAP;
                        irq      <= 1'b1;
                        epc      <= pc_cur;
                        cause    <= CAUSE_IRQ_BASE + CAUSE_W'(sel_index);
                        ack_mask <= sel_onehot;
                    end
                end
                TRAP: begin
                    state         <= VECTOR;
                    pc_redirect   <= 1'b1;
                    redirect_pc   <= VECTOR_ADDR;
                    supervisorBit <= 1'b1;
                    irq_ack       <= ack_mask;
                end
                VECTOR: begin
                    state <= HANDLER;
                end
                HANDLER: begin
                    // A fault inside the handler is recorded but never re-trapped,
                    // so the original epc/cause survive for the eret.
                    if (retire && illOp) double_fault <= 1'b1;
                    if (retire && eret) begin
                        state       <= RETURN;
                        pc_redirect <= 1'b1;
                        redirect_pc <= epc;
                    end
                end
                RETURN: begin
                    state         <= RUN;
                    supervisorBit <= 1'b0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctl.sv
// Directed bench for exc_ctl: trap entry, priority, masking, nesting, double fault, reset.
module tb_exc_ctl;
    import exc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_req;
    logic        irq_en;
    logic        retire;
    logic        illOp;
    logic        eret;
    logic [31:0] pc_cur;
    logic        irq;
    logic        supervisorBit;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [3:0]  cause;
    logic [3:0]  irq_ack;
    logic        double_fault;

    int checks = 0;
    int errors = 0;

    exc_ctl #(.IRQ_LINES(4), .VECTOR_ADDR(32'h0000_0080)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .irq_req       (irq_req),
        .irq_en        (irq_en),
        .retire        (retire),
        .illOp         (illOp),
        .eret          (eret),
        .pc_cur        (pc_cur),
        .irq           (irq),
        .supervisorBit (supervisorBit),
        .pc_redirect   (pc_redirect),
        .redirect_pc   (redirect_pc),
        .epc           (epc),
        .cause         (cause),
        .irq_ack       (irq_ack),
        .double_fault  (double_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        retire = 1'b0;
        illOp  = 1'b0;
        eret   = 1'b0;
    endtask

    // Drive an eret out of HANDLER and back into RUN (two cycles).
    task automatic leave_handler();
        retire = 1'b1; eret = 1'b1; pc_cur = 32'hF00;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; irq_req = '0; irq_en = 1'b0; pc_cur = '0;
        idle_inputs();
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({irq, supervisorBit, pc_redirect, irq_ack, double_fault} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0", {irq, supervisorBit, pc_redirect, irq_ack, double_fault});
        end
        checks++;
        if ({redirect_pc, epc, cause} !== 68'h0) begin
            errors++; $display("FAIL reset_data: redirect_pc=%h epc=%h cause=%0d expected all 0", redirect_pc, epc, cause);
        end
        checks++;
        if (u_dut.state !== RUN || u_dut.pending !== 4'b0) begin
            errors++; $display("FAIL reset_state: state=%0d pending=%b expected RUN/0000", u_dut.state, u_dut.pending);
        end
    endtask

    task automatic test_illop();
        retire = 1'b1; eret = 1'b1; pc_cur = 32'h20;
        tick();
        idle_inputs();
        checks++;
        if (irq !== 1'b0 || pc_redirect !== 1'b0 || u_dut.state !== RUN) begin
            errors++; $display("FAIL eret_in_run: irq=%b redirect=%b state=%0d expected 0/0/RUN", irq, pc_redirect, u_dut.state);
        end
        retire = 1'b1; illOp = 1'b1; pc_cur = 32'h40;
        tick();
        idle_inputs();
        checks++;
        if (irq !== 1'b1 || epc !== 32'h40 || cause !== 4'd1 || supervisorBit !== 1'b0 || pc_redirect !== 1'b0) begin
            errors++; $display("FAIL illop_trap: irq=%b epc=%h cause=%0d sup=%b redir=%b expected 1/40/1/0/0", irq, epc, cause, supervisorBit, pc_redirect);
        end
        tick();
        checks++;
        if (pc_redirect !== 1'b1 || redirect_pc !== 32'h80 || supervisorBit !== 1'b1 || irq_ack !== 4'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL illop_vector: redir=%b rpc=%h sup=%b ack=%b irq=%b expected 1/80/1/0000/0", pc_redirect, redirect_pc, supervisorBit, irq_ack, irq);
        end
        tick();
        checks++;
        if (pc_redirect !== 1'b0 || supervisorBit !== 1'b1 || u_dut.state !== HANDLER) begin
            errors++; $display("FAIL illop_handler: redir=%b sup=%b state=%0d expected 0/1/HANDLER", pc_redirect, supervisorBit, u_dut.state);
        end
        retire = 1'b1; eret = 1'b1; pc_cur = 32'h90;
        tick();
        idle_inputs();
        checks++;
        if (pc_redirect !== 1'b1 || redirect_pc !== 32'h40 || supervisorBit !== 1'b1) begin
            errors++; $display("FAIL illop_return: redir=%b rpc=%h sup=%b expected 1/40/1", pc_redirect, redirect_pc, supervisorBit);
        end
        tick();
        checks++;
        if (supervisorBit !== 1'b0 || pc_redirect !== 1'b0 || u_dut.state !== RUN) begin
            errors++; $display("FAIL illop_run: sup=%b redir=%b state=%0d expected 0/0/RUN", supervisorBit, pc_redirect, u_dut.state);
        end
    endtask

    task automatic test_priority();
        irq_en = 1'b1; irq_req = 4'b0110;
        tick();
        retire = 1'b1; pc_cur = 32'h100;
        tick();
        idle_inputs();
        checks++;
        if (irq !== 1'b1 || cause !== 4'd9 || epc !== 32'h100) begin
            errors++; $display("FAIL prio_trap: irq=%b cause=%0d epc=%h expected 1/9/100", irq, cause, epc);
        end
        tick();
        checks++;
        if (irq_ack !== 4'b0010) begin
            errors++; $display("FAIL prio_ack: got %b expected 0010", irq_ack);
        end
        tick();
        checks++;
        if (u_dut.pending !== 4'b0100 || irq_ack !== 4'b0000) begin
            errors++; $display("FAIL prio_pending: pending=%b ack=%b expected 0100/0000", u_dut.pending, irq_ack);
        end
        leave_handler();
        retire = 1'b1; pc_cur = 32'h200;
        tick();
        idle_inputs();
        checks++;
        if (irq !== 1'b1 || cause !== 4'd10 || epc !== 32'h200) begin
            errors++; $display("FAIL prio_second: irq=%b cause=%0d epc=%h expected 1/10/200", irq, cause, epc);
        end
        tick();
        checks++;
        if (irq_ack !== 4'b0100) begin
            errors++; $display("FAIL prio_ack2: got %b expected 0100", irq_ack);
        end
        tick();
        leave_handler();
        irq_req = '0;
    endtask

    task automatic test_masking();
        int traps;
        traps = 0;
        irq_en = 1'b0; irq_req = 4'b0001;
        tick();
        for (int i = 0; i < 20; i++) begin
            retire = 1'b1; pc_cur = 32'h200 + 32'(i * 4);
            tick();
            if (irq === 1'b1) traps++;
        end
        idle_inputs();
        checks++;
        if (traps !== 0 || u_dut.pending !== 4'b0001) begin
            errors++; $display("FAIL mask_hold: traps=%0d pending=%b expected 0/0001", traps, u_dut.pending);
        end
        irq_en = 1'b1; retire = 1'b1; pc_cur = 32'h300;
        tick();
        idle_inputs();
        checks++;
        if (irq !== 1'b1 || cause !== 4'd8 || epc !== 32'h300) begin
            errors++; $display("FAIL mask_enable: irq=%b cause=%0d epc=%h expected 1/8/300", irq, cause, epc);
        end
        tick();
        checks++;
        if (irq_ack !== 4'b0001) begin
            errors++; $display("FAIL mask_ack: got %b expected 0001", irq_ack);
        end
        tick();
        leave_handler();
        irq_req = '0;
    endtask

    task automatic test_nesting();
        int traps;
        traps = 0;
        retire = 1'b1; illOp = 1'b1; pc_cur = 32'h500;
        tick();
        idle_inputs();
        tick(); tick();
        irq_req = 4'b1000;
        tick();
        for (int i = 0; i < 3; i++) begin
            retire = 1'b1; pc_cur = 32'h84 + 32'(i * 4);
            tick();
            if (irq === 1'b1 || u_dut.state !== HANDLER) traps++;
        end
        idle_inputs();
        checks++;
        if (traps !== 0 || u_dut.pending !== 4'b1000 || supervisorBit !== 1'b1) begin
            errors++; $display("FAIL nest_hold: taken=%0d pending=%b sup=%b expected 0/1000/1", traps, u_dut.pending, supervisorBit);
        end
        retire = 1'b1; eret = 1'b1; pc_cur = 32'h98;
        tick();
        idle_inputs();
        checks++;
        if (pc_redirect !== 1'b1 || redirect_pc !== 32'h500) begin
            errors++; $display("FAIL nest_return: redir=%b rpc=%h expected 1/500", pc_redirect, redirect_pc);
        end
        tick();
        checks++;
        if (supervisorBit !== 1'b0) begin
            errors++; $display("FAIL nest_sup: got %b expected 0", supervisorBit);
        end
        retire = 1'b1; pc_cur = 32'h600;
        tick();
        idle_inputs();
        checks++;
        if (irq !== 1'b1 || cause !== 4'd11 || epc !== 32'h600) begin
            errors++; $display("FAIL nest_pending: irq=%b cause=%0d epc=%h expected 1/11/600", irq, cause, epc);
        end
        tick(); tick();
        leave_handler();
        irq_req = '0;
    endtask

    task automatic test_double_fault();
        retire = 1'b1; illOp = 1'b1; pc_cur = 32'h700;
        tick();
        idle_inputs();
        tick(); tick();
        retire = 1'b1; illOp = 1'b1; pc_cur = 32'h740;
        tick();
        idle_inputs();
        checks++;
        if (double_fault !== 1'b1 || epc !== 32'h700 || cause !== 4'd1) begin
            errors++; $display("FAIL dfault_set: df=%b epc=%h cause=%0d expected 1/700/1", double_fault, epc, cause);
        end
        checks++;
        if (u_dut.state !== HANDLER || supervisorBit !== 1'b1 || irq !== 1'b0) begin
            errors++; $display("FAIL dfault_state: state=%0d sup=%b irq=%b expected HANDLER/1/0", u_dut.state, supervisorBit, irq);
        end
        leave_handler();
        tick();
        checks++;
        if (double_fault !== 1'b1) begin
            errors++; $display("FAIL dfault_sticky: got %b expected 1", double_fault);
        end
    endtask

    task automatic test_reset_mid_trap();
        irq_en = 1'b1; irq_req = 4'b0010;
        tick();
        retire = 1'b1; pc_cur = 32'h800;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (u_dut.state !== VECTOR || pc_redirect !== 1'b1) begin
            errors++; $display("FAIL rst_setup: state=%0d redir=%b expected VECTOR/1", u_dut.state, pc_redirect);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; irq_req = '0;
        checks++;
        if ({irq, supervisorBit, pc_redirect, irq_ack, double_fault} !== 8'h00 || {redirect_pc, epc, cause} !== 68'h0) begin
            errors++; $display("FAIL rst_mid_outputs: ctrl=%b rpc=%h epc=%h cause=%0d expected all 0", {irq, supervisorBit, pc_redirect, irq_ack, double_fault}, redirect_pc, epc, cause);
        end
        checks++;
        if (u_dut.state !== RUN || u_dut.pending !== 4'b0) begin
            errors++; $display("FAIL rst_mid_state: state=%0d pending=%b expected RUN/0000", u_dut.state, u_dut.pending);
        end
    endtask

    initial begin
        test_reset();
        test_illop();
        test_priority();
        test_masking();
        test_nesting();
        test_double_fault();
        test_reset_mid_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
